// File: rtl/tmds_video_timing_ctrl.sv
// tmds_video_timing_ctrl: pixel-clock video timing sequencer for the TMDS encoder.
// Generates registered hsync/vsync/de/coordinates plus a one-cycle-early pixel request.
module tmds_video_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CW       = 12
) (
  input  logic          i_pixclk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_pix_valid,
  input  logic          i_clr_underflow,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic          o_pix_req,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_underflow
);
  localparam logic [CW-1:0] H_END = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_END = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_A   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_A   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS0   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, fs_q, fs_d, uf_q, uf_d;
  logic          go, act;

  // Dropping i_en takes effect on the very next edge, so the decode is gated by it too.
  always_comb begin
    state_d = i_en ? RUN : IDLE;
    go      = (state_q == RUN) && i_en;
    act     = go && (h_cnt_q < H_A) && (v_cnt_q < V_A);
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (go) begin
      h_cnt_d = (h_cnt_q == H_END) ? '0 : h_cnt_q + CW'(1);
      v_cnt_d = (h_cnt_q != H_END) ? v_cnt_q : (v_cnt_q == V_END) ? '0 : v_cnt_q + CW'(1);
    end
    de_d    = act;
    x_d     = act ? h_cnt_q : '0;
    y_d     = act ? v_cnt_q : '0;
    fs_d    = go && (h_cnt_q == '0) && (v_cnt_q == '0);
    hsync_d = (go && h_cnt_q >= HS0 && h_cnt_q < HS1) ? H_POL : ~H_POL;
    vsync_d = (go && v_cnt_q >= VS0 && v_cnt_q < VS1) ? V_POL : ~V_POL;
    uf_d    = (de_q && !i_pix_valid) || (uf_q && !i_clr_underflow);
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      uf_q    <= uf_d;
    end
  end

  assign o_pix_req     = act;
  assign o_de          = de_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = fs_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_underflow   = uf_q;
endmodule

// File: tb/tb_tmds_video_timing_ctrl.sv
// tb_tmds_video_timing_ctrl: directed table-driven bench on a 14x7 toy raster
// (H 8/2/2/2, V 4/1/1/1, active-high syncs).
module tb_tmds_video_timing_ctrl;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n, en, pix_valid, clr;
  logic          o_hsync, o_vsync, o_de, o_pix_req, o_frame_start, o_underflow;
  logic [CW-1:0] o_x, o_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          req;
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vec_t;

  vec_t tbl[16];

  tmds_video_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(CW)
  ) dut (
    .i_pixclk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_pix_valid(pix_valid),
    .i_clr_underflow(clr),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_de(o_de),
    .o_pix_req(o_pix_req),
    .o_x(o_x),
    .o_y(o_y),
    .o_frame_start(o_frame_start),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {3'b0, o_pix_req, o_de, o_hsync, o_vsync, o_frame_start, o_x[11:0], o_y[11:0]};
  endfunction

  function automatic logic [31:0] pack_vec(input vec_t v);
    return {3'b0, v.req, v.de, v.hs, v.vs, v.fs, v.x, v.y};
  endfunction

  function automatic bit hit(input int k);
    case (k)
      0:       return o_frame_start;
      1:       return o_de && o_x == 3 && o_y == 2;
      2:       return o_de && o_x == 5 && o_y == 1;
      3:       return o_hsync;
      default: return o_de;
    endcase
  endfunction

  task automatic wait_until(input int k, input string nm);
    int n = 0;
    while (!hit(k) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (!hit(k)) begin
      errors++;
      $display("FAIL %s: condition not reached after %0d cycles", nm, n);
    end
  endtask

  initial begin
    vec_t z;
    z = '{0, 0, 0, 0, 0, 0, 0};
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 2, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 3, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 4, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 5, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 6, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 7, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    en = 1'b1;
    pix_valid = 1'b1;
    clr = 1'b0;
    tick();
    tick();
    chk("reset_outputs", pack_out(), pack_vec(z));
    chk("reset_underflow", {31'b0, o_underflow}, 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("startup_edge%0d", i + 1), pack_out(), pack_vec(tbl[i]));
    end

    // Free run over three whole frames, measured from a frame_start sample.
    wait_until(0, "wait_frame_start");
    begin
      int  de_n = 0, vs_n = 0, fs_n = 0, hs_n = 0;
      logic req_prev;
      req_prev = o_pix_req;
      for (int t = 1; t <= 294; t++) begin
        int   pos, line;
        vec_t e;
        tick();
        pos = t % 14;
        line = (t / 14) % 7;
        e.de = pos < 8 && line < 4;
        e.req = 1'b0;
        e.hs = pos == 10 || pos == 11;
        e.vs = line == 5;
        e.fs = (t % 98) == 0;
        e.x = e.de ? CW'(pos) : '0;
        e.y = e.de ? CW'(line) : '0;
        chk($sformatf("run_t%0d", t), pack_out() & ~(32'd1 << 28), pack_vec(e));
        chk($sformatf("req_lead_t%0d", t), {31'b0, o_de}, {31'b0, req_prev});
        req_prev = o_pix_req;
        de_n += int'(o_de);
        vs_n += int'(o_vsync);
        hs_n += int'(o_hsync);
        fs_n += int'(o_frame_start);
      end
      chk("de_count", de_n, 96);
      chk("vsync_count", vs_n, 42);
      chk("hsync_count", hs_n, 42);
      chk("frame_start_count", fs_n, 3);
    end

    // Underflow: set, sticky, clear, and set-wins-over-clear.
    wait_until(1, "wait_pixel_3_2");
    chk("uf_before", {31'b0, o_underflow}, 32'd0);
    pix_valid = 1'b0;
    tick();
    pix_valid = 1'b1;
    chk("uf_set", {31'b0, o_underflow}, 32'd1);
    tick();
    tick();
    chk("uf_sticky", {31'b0, o_underflow}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("uf_clear", {31'b0, o_underflow}, 32'd0);
    wait_until(4, "wait_de_a");
    pix_valid = 1'b0;
    tick();
    pix_valid = 1'b1;
    chk("uf_set_again", {31'b0, o_underflow}, 32'd1);
    wait_until(4, "wait_de_b");
    pix_valid = 1'b0;
    clr = 1'b1;
    tick();
    pix_valid = 1'b1;
    clr = 1'b0;
    chk("uf_set_wins", {31'b0, o_underflow}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("uf_clear_again", {31'b0, o_underflow}, 32'd0);

    // Abort mid-frame at (5,1), then restart from (0,0).
    wait_until(2, "wait_pixel_5_1");
    en = 1'b0;
    tick();
    chk("abort_next_cycle", pack_out(), pack_vec(z));
    tick();
    tick();
    chk("idle_hold", pack_out(), pack_vec(z));
    en = 1'b1;
    tick();
    chk("restart_edge1", pack_out(), pack_vec(tbl[0]));
    tick();
    chk("restart_edge2", pack_out(), pack_vec(tbl[1]));
    tick();
    chk("restart_edge3", pack_out(), pack_vec(tbl[2]));

    // Asynchronous reset in the middle of hsync.
    wait_until(3, "wait_hsync");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hsync", {31'b0, o_hsync}, 32'd0);
    chk("async_rst_outputs", pack_out(), pack_vec(z));
    chk("async_rst_hcnt", {20'b0, dut.h_cnt_q}, 32'd0);
    chk("async_rst_vcnt", {20'b0, dut.v_cnt_q}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
